mac_array_seq: RTL and testbench

- Sequencer for the N_MACS-wide MAC row in the top-level system.
- On start it clears all accumulators, streams k_len operand reads from the operand buffer, and generates per-MAC enables skewed one cycle per column so operands can ripple through the row.
- It waits for the skew pipeline to drain, then pulses done.
- It also services the standalone clear_all request. All outputs are registered.

---
 rtl/mac_array_seq.sv | 144 ++++++++++++++
 tb/tb_mac_array_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq.sv
// Sequencer for an N_MACS-wide MAC row: clears the accumulators, streams operand
// reads and produces column-skewed accumulate enables, then pulses done.
module mac_array_seq #(
    parameter int N_MACS = 4,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear_all,
    input  logic [ADDR_W:0]   k_len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [N_MACS-1:0] mac_clear,
    output logic [N_MACS-1:0] mac_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // The skew line holds rd_en for RD_LAT cycles of read latency plus one stage per extra column.
    localparam int PIPE_LEN = RD_LAT + N_MACS - 1;
    localparam int DRAIN_W  = $clog2(PIPE_LEN + 1);
    localparam logic [ADDR_W:0]    K_MAX      = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]    K_ONE      = (ADDR_W + 1)'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LEN - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     k_len_reg;
    logic [ADDR_W:0]     run_cnt_reg;
    logic [DRAIN_W-1:0]  drain_cnt_reg;
    logic [PIPE_LEN-1:0] pipe_reg;

    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                rd_en_reg, rd_en_next;
    logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
    logic                clear_reg, clear_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (k_len == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: state_next = S_FEED;
            S_FEED: begin
                if (run_cnt_reg == k_len_reg - K_ONE) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Decoded from the current state and registered, so every output lags its state by one edge.
    always_comb begin
        busy_next    = (state_reg == S_CLEAR) || (state_reg == S_FEED) || (state_reg == S_DRAIN);
        done_next    = (state_reg == S_DONE);
        rd_en_next   = (state_reg == S_FEED);
        rd_addr_next = (state_reg == S_FEED) ? run_cnt_reg[ADDR_W-1:0] : '0;
        clear_next   = (state_reg == S_CLEAR) ||
                       ((state_reg == S_IDLE) && clear_all && !start);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            clear_reg   <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            rd_en_reg   <= rd_en_next;
            rd_addr_reg <= rd_addr_next;
            clear_reg   <= clear_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_len_reg     <= '0;
            run_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
        end else begin
            if ((state_reg == S_IDLE) && start) begin
                k_len_reg <= (k_len > K_MAX) ? K_MAX : k_len;
            end
            run_cnt_reg   <= (state_reg == S_FEED)  ? run_cnt_reg + K_ONE : '0;
            drain_cnt_reg <= (state_reg == S_DRAIN) ? drain_cnt_reg + DRAIN_W'(1) : '0;
        end
    end

    generate
        for (genvar gi = 0; gi < PIPE_LEN; gi++) begin : g_pipe
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    pipe_reg[gi] <= rd_en_reg;
                end else begin
                    pipe_reg[gi] <= pipe_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end

        for (genvar gi = 0; gi < N_MACS; gi++) begin : g_en
            assign mac_en[gi]    = pipe_reg[RD_LAT - 1 + gi];
            assign mac_clear[gi] = clear_reg;
        end
    endgenerate

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_en   = rd_en_reg;
    assign rd_addr = rd_addr_reg;

endmodule

// File: tb/tb_mac_array_seq.sv
// Bench for mac_array_seq: directed and randomized runs checked against
// interval formulas for each output, relative to the cycle start is sampled.
module tb_mac_array_seq;

    localparam int N    = 4;
    localparam int AW   = 4;
    localparam int RL   = 1;
    localparam int KMAX = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          clear_all = 1'b0;
    logic [AW:0]   k_len = '0;
    logic          busy, done, rd_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  mac_clear, mac_en;

    int n_vec  = 0;
    int n_miss = 0;

    mac_array_seq #(.N_MACS(N), .ADDR_W(AW), .RD_LAT(RL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear_all (clear_all),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .mac_clear (mac_clear),
        .mac_en    (mac_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".rd_en"},     32'(rd_en),     32'd0);
        chk({tag, ".mac_clear"}, 32'(mac_clear), 32'd0);
        chk({tag, ".mac_en"},    32'(mac_en),    32'd0);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_zero(tag);
        end
    endtask

    // Edge 0 is the next rising edge; expected waveforms follow from the run-timing rules.
    task automatic run(input int k, input bit noisy, input int poke_cyc);
        int kc, tdone;
        logic [N-1:0] exp_me, exp_clr;
        logic exp_busy, exp_done, exp_rd;
        kc    = (k > KMAX) ? KMAX : k;
        tdone = (kc == 0) ? 1 : kc + RL + N + 1;
        start     = 1'b1;
        k_len     = (AW + 1)'(k);
        clear_all = 1'($urandom_range(0, 1));
        for (int c = 0; c <= tdone; c++) begin
            @(posedge clk); #1;
            exp_busy = (kc != 0) && (c >= 1) && (c <= kc + RL + N);
            exp_done = (c == tdone);
            exp_rd   = (kc != 0) && (c >= 2) && (c <= kc + 1);
            exp_clr  = ((kc != 0) && (c == 1)) ? '1 : '0;
            for (int i = 0; i < N; i++) begin
                exp_me[i] = (kc != 0) && (c >= 2 + RL + i) && (c <= 1 + RL + i + kc);
            end
            chk("busy",      32'(busy),      32'(exp_busy));
            chk("done",      32'(done),      32'(exp_done));
            chk("rd_en",     32'(rd_en),     32'(exp_rd));
            chk("mac_clear", 32'(mac_clear), 32'(exp_clr));
            chk("mac_en",    32'(mac_en),    32'(exp_me));
            if (exp_rd) begin
                chk("rd_addr", 32'(rd_addr), 32'(c - 2));
            end
            if (noisy && c < tdone) begin
                start     = 1'($urandom_range(0, 1));
                clear_all = 1'($urandom_range(0, 1));
                k_len     = (AW + 1)'($urandom);
            end else begin
                start     = (c == poke_cyc - 1) ? 1'b1 : 1'b0;
                clear_all = 1'b0;
            end
        end
        $display("run k_len=%0d (effective %0d) noisy=%0d: done expected at cycle %0d", k, kc, noisy, tdone);
    endtask

    initial begin
        int cnt;
        // Reset held, then released into a quiet IDLE.
        repeat (3) @(posedge clk);
        #1;
        check_zero("in_reset");
        rst = 1'b1;
        idle(10, "idle_after_reset");
        $display("reset and idle checked");

        // Standalone clear request.
        clear_all = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            clear_all = 1'b0;
            if (mac_clear == '1) cnt++;
            chk("clr.busy",  32'(busy),   32'd0);
            chk("clr.rd_en", 32'(rd_en),  32'd0);
            chk("clr.mac_en",32'(mac_en), 32'd0);
            chk("clr.shape", 32'((mac_clear == '0) || (mac_clear == '1)), 32'd1);
        end
        chk("clr.pulse_count", 32'(cnt), 32'd1);
        $display("clear_all pulse: %0d cycles of mac_clear", cnt);

        run(8, 1'b0, 5);
        idle(2, "after_k8");
        run(0, 1'b0, -1);
        idle(2, "after_k0");
        run(16, 1'b0, -1);
        idle(1, "after_k16");
        run(31, 1'b0, -1);
        run(3, 1'b0, -1);

        // Reset asserted mid-run: outputs drop without waiting for a clock edge.
        start = 1'b1;
        k_len = 5'd8;
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(20, "after_midrun_reset");
        $display("mid-run reset checked");
        run(5, 1'b0, -1);

        for (int r = 0; r < 12; r++) begin
            run($urandom_range(0, 31), 1'b1, -1);
            idle($urandom_range(0, 2), "random_gap");
        end
        idle(3, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
